// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline stage with 2-entry skid buffer and flush
module pipe_stage_elastic #(
  parameter int DATA_W = 165,
  parameter int CTRL_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        count_o
);

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic              in_fire;

  // in_ready_o depends only on s_valid, so out_ready_i never reaches it combinationally
  assign in_ready_o  = ~s_valid;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_valid_o = m_valid;
  assign out_data_o  = m_data;
  assign out_ctrl_o  = m_valid ? m_ctrl : '0;
  assign count_o     = {1'b0, m_valid} + {1'b0, s_valid};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
      m_ctrl  <= '0;
      s_ctrl  <= '0;
    end else if (flush_i) begin
      // payload regs keep their value; only validity and control are squashed
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_ctrl  <= '0;
      s_ctrl  <= '0;
    end else if (!s_valid) begin
      if (!m_valid || out_ready_i) begin
        m_valid <= in_fire;
        m_data  <= in_data_i;
        m_ctrl  <= in_valid_i ? in_ctrl_i : '0;
      end else if (in_fire) begin
        s_valid <= 1'b1;
        s_data  <= in_data_i;
        s_ctrl  <= in_ctrl_i;
      end
    end else if (out_ready_i) begin
      m_valid <= 1'b1;
      m_data  <= s_data;
      m_ctrl  <= s_ctrl;
      s_valid <= 1'b0;
      s_ctrl  <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - randomized scoreboard bench for pipe_stage_elastic
module tb_pipe_stage_elastic;
  localparam int DW = 165;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i = '0;
  logic [CW-1:0] in_ctrl_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_data_o;
  logic [CW-1:0] out_ctrl_o;
  logic [1:0]    count_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] qd[$];
  logic [CW-1:0] qc[$];

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_ctrl_o(out_ctrl_o), .count_o(count_o)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // expected outputs follow directly from the FIFO contents of the model
  task automatic check_outputs();
    check_eq("count", 256'(count_o), 256'(qd.size()));
    check_eq("out_valid", 256'(out_valid_o), 256'(qd.size() > 0));
    check_eq("in_ready", 256'(in_ready_o), 256'(qd.size() < 2));
    check_eq("out_ctrl", 256'(out_ctrl_o), (qd.size() > 0) ? 256'(qc[0]) : 256'(0));
    if (qd.size() > 0) check_eq("out_data", 256'(out_data_o), 256'(qd[0]));
  endtask

  // one clock: drive at negedge, update the model at posedge, check at next negedge
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input logic r, input logic f);
    logic ifire, ofire, hold;
    logic [DW-1:0] held;
    in_valid_i = v; in_data_i = d; in_ctrl_i = c; out_ready_i = r; flush_i = f;
    ifire = v && (qd.size() < 2);
    ofire = r && (qd.size() > 0);
    hold  = out_valid_o && !r && !f;
    held  = out_data_o;
    @(posedge clk);
    if (f) begin
      qd.delete(); qc.delete();
    end else begin
      if (ofire) begin void'(qd.pop_front()); void'(qc.pop_front()); end
      if (ifire) begin qd.push_back(d); qc.push_back(c); end
    end
    @(negedge clk);
    check_outputs();
    if (hold) check_eq("stall_stable", 256'(out_data_o), 256'(held));
  endtask

  initial begin
    // reset for two cycles
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 256'(in_ready_o), 256'(1));
    check_eq("rst_valid", 256'(out_valid_o), 256'(0));
    check_eq("rst_ctrl", 256'(out_ctrl_o), 256'(0));
    check_eq("rst_data", 256'(out_data_o), 256'(0));
    check_eq("rst_count", 256'(count_o), 256'(0));
    rst_i = 1'b1;

    // stream 1,2,3,...
    for (int i = 1; i <= 6; i++) cyc(1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
    check_eq("stream_data", 256'(out_data_o), 256'(6));

    // bubble with ctrl=FF
    cyc(1'b0, DW'(77), 8'hFF, 1'b1, 1'b0);
    check_eq("bubble_valid", 256'(out_valid_o), 256'(0));
    check_eq("bubble_ctrl", 256'(out_ctrl_o), 256'(0));

    // backpressure: A in M, then B into skid, C refused until drain
    cyc(1'b1, DW'(16'hA), 8'h0A, 1'b1, 1'b0);
    cyc(1'b1, DW'(16'hB), 8'h0B, 1'b0, 1'b0);
    check_eq("bp_count2", 256'(count_o), 256'(2));
    cyc(1'b1, DW'(16'hC), 8'h0C, 1'b0, 1'b0);
    check_eq("bp_ready0", 256'(in_ready_o), 256'(0));
    check_eq("bp_head_a", 256'(out_data_o), 256'(16'hA));
    cyc(1'b1, DW'(16'hC), 8'h0C, 1'b1, 1'b0);
    check_eq("bp_head_b", 256'(out_data_o), 256'(16'hB));
    cyc(1'b1, DW'(16'hC), 8'h0C, 1'b1, 1'b0);
    check_eq("bp_head_c", 256'(out_data_o), 256'(16'hC));
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // flush while full with data 9 offered
    cyc(1'b1, DW'(1), 8'h11, 1'b0, 1'b0);
    cyc(1'b1, DW'(2), 8'h22, 1'b0, 1'b0);
    check_eq("fl_full", 256'(count_o), 256'(2));
    cyc(1'b1, DW'(9), 8'h99, 1'b0, 1'b1);
    check_eq("fl_count", 256'(count_o), 256'(0));
    check_eq("fl_ctrl", 256'(out_ctrl_o), 256'(0));
    check_eq("fl_ready", 256'(in_ready_o), 256'(1));
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // async reset in the middle of a stall
    cyc(1'b1, DW'(5), 8'h55, 1'b0, 1'b0);
    cyc(1'b1, DW'(6), 8'h66, 1'b0, 1'b0);
    check_eq("ar_full", 256'(count_o), 256'(2));
    #2 rst_i = 1'b0;
    #1;
    check_eq("ar_valid", 256'(out_valid_o), 256'(0));
    check_eq("ar_count", 256'(count_o), 256'(0));
    check_eq("ar_ready", 256'(in_ready_o), 256'(1));
    check_eq("ar_ctrl", 256'(out_ctrl_o), 256'(0));
    qd.delete(); qc.delete();
    @(negedge clk);
    rst_i = 1'b1;
    in_valid_i = 1'b0;

    // random valid/ready against the scoreboard
    for (int k = 0; k < 10000; k++) begin
      cyc(1'($urandom_range(0, 3) != 0), rand_data(), CW'($urandom),
          1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
